regfile_sb: RTL
===============

# regfile_sb

Parametrised integer register file with write-to-read bypass and a per-register busy scoreboard, the next generation of the core's 64-bit register file. It sits between decode (read ports, destination allocation) and writeback (write port). Decode uses the busy outputs to stall on registers whose producer is still in flight, such as loads and multi-cycle ops. All state clears on reset; there is no simulation-only preload.

## Interface
- XLEN, 64, register width in bits
- NREG, 32, number of architectural registers (power of two, ≥2); register 0 is hardwired zero
- AW, $clog2(NREG), address width (derived, not overridden)
- CW, $clog2(NREG+1), width of pending count (derived)

- clk  in  1  single clock, all state updates on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- rs1  in  AW  read address 1
- rs2  in  AW  read address 2
- rd1  out  XLEN  read data 1 (combinational)
- rd2  out  XLEN  read data 2 (combinational)
- busy1  out  1  register rs1 has an outstanding producer (combinational)
- busy2  out  1  register rs2 has an outstanding producer (combinational)
- wen  in  1  writeback enable
- wa  in  AW  writeback address
- wd  in  XLEN  writeback data
- alloc_en  in  1  decode issues an instruction that will later write alloc_rd
- alloc_rd  in  AW  destination being allocated
- flush  in  1  pipeline flush: cancel all outstanding allocations
- pending  out  CW  registered count of busy registers

## Operation
- Storage: NREG x XLEN registers plus an NREG-bit scoreboard sb. Entry 0 is never written and sb[0] is never set.
- Write: on clk, if wen and wa≠0, regs[wa] ← wd. wa=0 is ignored silently.
- Read port n (rsn):
  - rsn=0 → 0.
  - Otherwise, if wen and wa=rsn → wd (same-cycle bypass).
  - Otherwise → regs[rsn].
- Busy port n: busyn = sb[rsn] & ~(wen & wa=rsn) & (rsn≠0). A writeback in the same cycle releases the stall immediately.
- Scoreboard next state, per entry a≠0:
  - If flush, sb[a] ← 0.
  - Otherwise, sb[a] ← (sb[a] & ~(wen & wa=a)) | (alloc_en & alloc_rd=a).
- Priority:
  - flush beats alloc and writeback.
  - alloc to a register beats a simultaneous writeback to the same register. A new producer keeps the entry busy, and the data still commits.
- Writeback to a non-busy register is legal. It updates data and sb is unchanged (stays 0).
- alloc to a register that is already busy leaves it busy. There is no counting of multiple producers per register; only one producer may be outstanding per register.
- alloc_rd=0 has no effect.
- flush does not alter register contents, and a writeback in the flush cycle still commits data.
- pending: register equal to popcount of next-state sb, so it always equals the popcount of sb in the same cycle. Range 0..NREG-1.

## Timing
- Reset (rst_n=0, asynchronous, any time):
  - All regs = 0, sb = 0, pending = 0.
  - Consequently rd1, rd2, busy1 and busy2 evaluate to 0 during and after reset.
  - A reset mid-operation discards all allocations and data immediately, without waiting for clk.
- Read latency: 0 cycles, combinational from rs/wa/wd/wen. Data written at edge k is visible from regs after edge k and via bypass during cycle k.
- Busy set latency: alloc in cycle k → sb set after edge k, so busy is visible to a read in cycle k+1, not k.
- Busy clear latency: 0 cycles via the busy bypass; sb clears at the edge.
- pending changes only at clk edges, or asynchronously to 0 on reset.

## Test plan
- Reset then read: assert rst_n=0 mid-cycle after writing x5=0x1234 → rd1(rs1=5)=0, busy1=0 and pending=0 immediately, without a clock edge.
- Write/bypass:
  - wen=1, wa=7, wd=0xDEADBEEF_CAFEF00D with rs1=7 in the same cycle → rd1=0xDEADBEEF_CAFEF00D before the edge.
  - After the edge with wen=0 → same value.
  - wen=1, wa=0, wd=0xFF → rd1(rs1=0)=0.
- Scoreboard:
  - alloc x3 at edge k → busy2(rs2=3)=0 in cycle k, 1 in cycle k+1, pending=1.
  - wen, wa=3, wd=9 in cycle k+3 → busy2=0 and rd2=9 in that cycle; pending=0 after the edge.
- Simultaneous alloc and writeback to x4 while sb[4]=1 → after the edge sb[4]=1, regs[4]=wd, pending unchanged.
- flush with x1, x2, x9 busy plus alloc x10 in the same cycle → after the edge all busy=0, pending=0, register contents unchanged.
- Parameter sweep at XLEN=32, NREG=16: alloc all of x1..x15 → pending=15. Reads at x15 return written data, and widths are correct.

Source files
------------

// File: rtl/regfile_sb.sv
// Integer register file with write-to-read bypass and a per-register
// busy scoreboard used by decode to stall on in-flight producers.
module regfile_sb #(
   parameter  int XLEN = 64,
   parameter  int NREG = 32,
   localparam int AW   = $clog2(NREG),
   localparam int CW   = $clog2(NREG + 1)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [AW-1:0]   rs1,
   input  logic [AW-1:0]   rs2,
   output logic [XLEN-1:0] rd1,
   output logic [XLEN-1:0] rd2,
   output logic            busy1,
   output logic            busy2,
   input  logic            wen,
   input  logic [AW-1:0]   wa,
   input  logic [XLEN-1:0] wd,
   input  logic            alloc_en,
   input  logic [AW-1:0]   alloc_rd,
   input  logic            flush,
   output logic [CW-1:0]   pending
);

   logic [XLEN-1:0] regs [NREG];
   logic [NREG-1:0] sb;
   logic [NREG-1:0] sb_nxt;
   logic [CW-1:0]   cnt;
   logic            hit1;
   logic            hit2;

   assign hit1 = wen && (wa == rs1);
   assign hit2 = wen && (wa == rs2);

   always_comb begin
      rd1 = '0;
      if (rs1 != '0) rd1 = hit1 ? wd : regs[rs1];
   end

   always_comb begin
      rd2 = '0;
      if (rs2 != '0) rd2 = hit2 ? wd : regs[rs2];
   end

   assign busy1 = sb[rs1] & ~hit1 & (rs1 != '0);
   assign busy2 = sb[rs2] & ~hit2 & (rs2 != '0);

   // New allocation wins over a same-cycle release of the same entry
   always_comb begin
      sb_nxt = '0;
      if (!flush) begin
         for (int a = 1; a < NREG; a++) begin
            sb_nxt[a] = (sb[a] & ~(wen && (wa == AW'(a))))
                      | (alloc_en && (alloc_rd == AW'(a)));
         end
      end
   end

   always_comb begin
      cnt = '0;
      for (int a = 0; a < NREG; a++) cnt = cnt + CW'(sb_nxt[a]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else if (wen && (wa != '0)) begin
         regs[wa] <= wd;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sb      <= '0;
         pending <= '0;
      end else begin
         sb      <= sb_nxt;
         pending <= cnt;
      end
   end

endmodule
